timer_counter: RTL
==================

# timer_counter

Memory-mapped down-counting timer on the processor bus, placed directly downstream of the CPU's bus-master port. It decodes the CPU's bus address, write-enable and write-data signals and returns read data. Two instances, at base 0x7F00 and 0x7F10, drive the CPU's T0_irq and T1_irq interrupt inputs. Each instance has three word registers: CTRL, PRESET and COUNT. It supports one-shot and auto-reload modes, and its interrupt output is maskable.

## Interface
Parameters:
- BASE, 32'h0000_7F00, byte base address; instance hits when addr[31:4]==BASE[31:4] and addr[3:2]!=2'b11

Ports:
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- addr  in  32  byte address from CPU bus; addr[1:0] ignored
- we  in  1  write strobe; effective only on a hit
- wd  in  32  write data
- rd  out  32  read data, combinational; 0 when no hit
- irq  out  1  interrupt request to CPU

## Operation
Register map (offset from BASE):
- 0x0 CTRL: bit0 EN (count enable), bits2:1 MODE (00 one-shot, 01 auto-reload, 1x behave as 00), bit3 IM (interrupt mask, 1 = enabled). Bits31:4 are not stored and read as 0.
- 0x4 PRESET: 32-bit reload value, read/write.
- 0x8 COUNT: 32-bit current count. Read-only; writes are ignored.

Register writes:
- A write to CTRL or PRESET updates the register at the edge.
- A write to CTRL or PRESET also clears irq_flag.
- A CPU write to CTRL at the same edge as an FSM update of EN takes priority over the FSM.
- A write to PRESET does not disturb an in-progress count. It is used at the next LOAD.

FSM, 2-bit state:
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT<=PRESET, then go to CNT.
- CNT, checked in this order:
  - If EN=0, go to IDLE. COUNT holds its value.
  - Else if COUNT<=1: COUNT<=0, irq_flag<=1, go to INT.
  - Else COUNT<=COUNT-1.
- INT, one-shot mode: EN<=0, go to IDLE. irq_flag stays 1 until software writes CTRL or PRESET.
- INT, auto-reload mode: irq_flag<=0, go to LOAD.

Other rules:
- irq = irq_flag & IM, combinational.
- PRESET=0 behaves as PRESET=1: the timer reaches INT one edge after LOAD.
- COUNT arithmetic is unsigned 32-bit and never wraps below 0.

## Timing
Reset values: state=IDLE, CTRL=0, PRESET=0, COUNT=0, irq_flag=0, so irq=0. rd reflects the reset registers (0).

Latency from a CTRL write that sets EN (edge t):
- t+1: state enters LOAD.
- t+2: COUNT=PRESET, state enters CNT.
- t+2+PRESET: COUNT=0, state enters INT, irq_flag=1.
- irq is visible in the cycle after edge t+2+PRESET.

Auto-reload mode:
- Interrupt period is PRESET+2 cycles.
- irq is high for exactly 1 cycle per period when IM=1.

Other timing rules:
- Read-during-write: rd shows the old register value in the write cycle. The new value appears after the edge.
- Clearing EN mid-count freezes COUNT at the next edge. Setting EN again restarts the count from PRESET via LOAD.
- Asserting reset mid-count forces the reset values immediately, without waiting for a clock edge. Counting resumes only after software sets EN again.

## Test plan
- One-shot count: write PRESET=5 at edge 0, then CTRL=0x9 at edge 1.
  - COUNT reads 5,4,3,2,1,0 after edges 3..8.
  - irq rises after edge 8 and stays high.
  - CTRL reads 0x8 after edge 9.
  - Writing CTRL=0 drops irq after that edge.
- Auto-reload: PRESET=3, CTRL=0xB. irq pulses for 1 cycle every 5 cycles. COUNT sequence is 3,2,1,0,(LOAD hold),3,...
- Mask: PRESET=2, CTRL=0x1 (IM=0). The timer reaches 0 and EN clears. irq stays 0 throughout. Writing CTRL=0x8 afterwards leaves irq at 0, because the write clears irq_flag.
- Decode and read-only: with BASE=0x7F10:
  - A write to 0x7F18 leaves COUNT unchanged.
  - A read of 0x7F1C returns 0.
  - A write to 0x7F04 (the other instance) has no effect.
  - PRESET reads back 0xDEADBEEF after that value is written.
- Mid-operation:
  - Raise reset asynchronously at COUNT=7. All registers and irq read 0 before the next edge.
  - Write PRESET=100 mid-count with PRESET=10. The current run still ends at 0 after the original schedule.
- Zero preset: PRESET=0 with one-shot mode. INT is reached 1 edge after LOAD, and irq then asserts.

Source files
------------

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter
//  Description : Memory-mapped down-counting timer. It has three word
//                registers (CTRL, PRESET, COUNT), one-shot and auto-reload
//                modes, and a maskable interrupt request.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BASE  byte base address. The instance decodes addr[31:4] against
//          BASE[31:4]. Offset 0xC is unmapped.
//  Ports
//    clk    in   1   sole clock, rising edge
//    reset  in   1   asynchronous active-high reset
//    addr   in   32  CPU byte address (addr[1:0] ignored)
//    we     in   1   write strobe, effective only on a decode hit
//    wd     in   32  write data
//    rd     out  32  combinational read data, 0 when not addressed
//    irq    out  1   interrupt request (irq_flag & IM)
//  Register map
//    0x0 CTRL   : [0] EN, [2:1] MODE (01 = auto-reload, else one-shot), [3] IM
//    0x4 PRESET : reload value
//    0x8 COUNT  : current count, read-only
// ============================================================================
module timer_counter #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] c_OFS_CTRL   = 2'b00;
    localparam logic [1:0] c_OFS_PRESET = 2'b01;
    localparam logic [1:0] c_OFS_COUNT  = 2'b10;
    localparam logic [1:0] c_MODE_AUTO  = 2'b01;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_hit;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_auto;
    logic [31:0] w_count_nxt;
    logic        w_flag_nxt;
    logic        w_fsm_clr_en;

    // The byte-lane bits of the address play no part in decoding.
    logic        w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, addr[1:0]};

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign w_hit       = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11);
    assign w_wr_ctrl   = we && w_hit && (addr[3:2] == c_OFS_CTRL);
    assign w_wr_preset = we && w_hit && (addr[3:2] == c_OFS_PRESET);

    // MODE = 1x falls back to one-shot, so only the exact 01 code reloads.
    assign w_auto      = (r_mode == c_MODE_AUTO);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and datapath updates requested by the FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_flag_nxt   = r_irq_flag;
        w_fsm_clr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count <= 32'd1) begin
                    // A count of 0 (PRESET=0) terminates like a count of 1,
                    // so the counter never wraps below zero.
                    w_count_nxt = 32'd0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = S_INT;
                end else begin
                    w_count_nxt = r_count - 32'd1;
                end
            end
            S_INT: begin
                if (w_auto) begin
                    w_flag_nxt  = 1'b0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_fsm_clr_en = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers. A CPU write to CTRL wins over the FSM clearing EN, and any
    // CTRL/PRESET write clears the interrupt flag at the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_mode     <= 2'b00;
            r_im       <= 1'b0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            r_count <= w_count_nxt;

            if (w_wr_ctrl || w_wr_preset) begin
                r_irq_flag <= 1'b0;
            end else begin
                r_irq_flag <= w_flag_nxt;
            end

            if (w_wr_ctrl) begin
                r_en   <= wd[0];
                r_mode <= wd[2:1];
                r_im   <= wd[3];
            end else if (w_fsm_clr_en) begin
                r_en   <= 1'b0;
            end

            // PRESET is only sampled in LOAD, so a write never disturbs a
            // count already in progress.
            if (w_wr_preset) begin
                r_preset <= wd;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read mux and interrupt output
    // ------------------------------------------------------------------------
    always_comb begin
        rd = 32'd0;
        if (w_hit) begin
            case (addr[3:2])
                c_OFS_CTRL:   rd = {28'd0, r_im, r_mode, r_en};
                c_OFS_PRESET: rd = r_preset;
                c_OFS_COUNT:  rd = r_count;
                default:      rd = 32'd0;
            endcase
        end
    end

    assign irq = r_irq_flag & r_im;

endmodule
`default_nettype wire
